// File: rtl/regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : regfile_writeback
// Purpose  : Write-back arbiter and load scoreboard for the register file's
//            single write port. Single-cycle ALU results own the port when
//            present. Multi-cycle load results are queued in a small FIFO and
//            drained when the ALU leaves the port idle. A per-register busy
//            vector tracks destinations with an outstanding load.
// Ports    : clk, rst_n                    - clock, async active-low reset
//            alu_valid/alu_rd/alu_data     - ALU result, no backpressure
//            mem_valid/mem_ready/mem_rd/mem_data - load result handshake
//            issue_valid/issue_rd          - load issue, sets busy[issue_rd]
//            rf_we/rf_rd/rf_wd             - registered RF write port
//            busy                          - per-register load-pending flags
// Revision : 1.0 - initial release
// ============================================================================
module regfile_writeback #(
   parameter int DEPTH = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        alu_valid,
   input  logic [4:0]  alu_rd,
   input  logic [31:0] alu_data,
   input  logic        mem_valid,
   output logic        mem_ready,
   input  logic [4:0]  mem_rd,
   input  logic [31:0] mem_data,
   input  logic        issue_valid,
   input  logic [4:0]  issue_rd,
   output logic        rf_we,
   output logic [4:0]  rf_rd,
   output logic [31:0] rf_wd,
   output logic [31:0] busy
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

   // FIFO storage (no reset needed: validity is tracked by r_count)
   logic [4:0]       r_fifo_rd   [DEPTH];
   logic [31:0]      r_fifo_data [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic        w_push;
   logic        w_pop;
   logic        w_alu_take;
   logic [4:0]  w_head_rd;
   logic [31:0] w_head_data;
   logic [31:0] w_busy_next;

   // Ready depends only on the registered count, never on this cycle's pop,
   // so the load unit never sees a combinational path through arbitration.
   assign mem_ready   = (r_count < c_depth);
   assign w_push      = mem_valid & mem_ready;
   // A write to x0 is meaningless, so it must not steal the port from loads.
   assign w_alu_take  = alu_valid & (alu_rd != 5'd0);
   // Pop uses the pre-edge count, so an entry pushed this cycle is not
   // visible to the pop until the next cycle.
   assign w_pop       = ~w_alu_take & (r_count != '0);
   assign w_head_rd   = r_fifo_rd[r_rd_ptr];
   assign w_head_data = r_fifo_data[r_rd_ptr];

   // Clear first, then set, so a re-issue on the draining edge keeps busy.
   always_comb begin
      w_busy_next = busy;
      if (w_pop && (w_head_rd != 5'd0)) begin
         w_busy_next[w_head_rd] = 1'b0;
      end
      if (issue_valid && (issue_rd != 5'd0)) begin
         w_busy_next[issue_rd] = 1'b1;
      end
      w_busy_next[0] = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo_rd[r_wr_ptr]   <= mem_rd;
         r_fifo_data[r_wr_ptr] <= mem_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         rf_we    <= 1'b0;
         rf_rd    <= 5'd0;
         rf_wd    <= 32'd0;
         busy     <= 32'd0;
      end else begin
         // DEPTH is a power of two, so pointers wrap naturally.
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + c_one;
            2'b01:   r_count <= r_count - c_one;
            default: r_count <= r_count;
         endcase

         if (w_alu_take) begin
            rf_we <= 1'b1;
            rf_rd <= alu_rd;
            rf_wd <= alu_data;
         end else if (w_pop) begin
            // Loads to x0 still drain in order but produce no write.
            rf_we <= (w_head_rd != 5'd0);
            rf_rd <= w_head_rd;
            rf_wd <= w_head_data;
         end else begin
            rf_we <= 1'b0;
         end

         busy <= w_busy_next;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_regfile_writeback.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_writeback
// Purpose  : Self-checking bench for regfile_writeback: a directed vector
//            table, hand-written reset sequence, and randomized traffic
//            compared against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_writeback;

   localparam int DEPTH = 2;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        mem_valid;
   logic        mem_ready;
   logic [4:0]  mem_rd;
   logic [31:0] mem_data;
   logic        issue_valid;
   logic [4:0]  issue_rd;
   logic        rf_we;
   logic [4:0]  rf_rd;
   logic [31:0] rf_wd;
   logic [31:0] busy;

   int checks = 0;
   int errors = 0;

   regfile_writeback #(.DEPTH(DEPTH)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .rf_we       (rf_we),
      .rf_rd       (rf_rd),
      .rf_wd       (rf_wd),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- reference model ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } entry_t;

   entry_t      m_q[$];
   logic [31:0] m_busy;
   logic        m_we;
   logic [4:0]  m_rd;
   logic [31:0] m_wd;

   task automatic model_reset();
      m_q.delete();
      m_busy = 0;
      m_we   = 0;
      m_rd   = 0;
      m_wd   = 0;
   endtask

   // Applies one clock edge worth of behaviour using the held inputs.
   task automatic model_step();
      bit     accept;
      entry_t e;
      accept = mem_valid && (m_q.size() < DEPTH);
      if (alu_valid && alu_rd != 0) begin
         m_we = 1; m_rd = alu_rd; m_wd = alu_data;
      end else if (m_q.size() > 0) begin
         e = m_q.pop_front();
         m_we = (e.rd != 0); m_rd = e.rd; m_wd = e.data;
         if (e.rd != 0) m_busy[e.rd] = 1'b0;
      end else begin
         m_we = 0;
      end
      if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
      if (accept) begin
         e.rd = mem_rd; e.data = mem_data;
         m_q.push_back(e);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md,
                        input logic iv, input logic [4:0] ir);
      alu_valid = av; alu_rd = ar; alu_data = ad;
      mem_valid = mv; mem_rd = mr; mem_data = md;
      issue_valid = iv; issue_rd = ir;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic        av; logic [4:0] ar; logic [31:0] ad;
      logic        mv; logic [4:0] mr; logic [31:0] md;
      logic        iv; logic [4:0] ir;
      logic        e_we; logic [4:0] e_rd; logic [31:0] e_wd;
      logic [31:0] e_busy; logic e_ready;
   } vec_t;

   vec_t vecs[22];

   function automatic vec_t mk(logic av, logic [4:0] ar, logic [31:0] ad,
                               logic mv, logic [4:0] mr, logic [31:0] md,
                               logic iv, logic [4:0] ir,
                               logic ew, logic [4:0] er, logic [31:0] ed,
                               logic [31:0] eb, logic ey);
      vec_t v;
      v.av = av; v.ar = ar; v.ad = ad; v.mv = mv; v.mr = mr; v.md = md;
      v.iv = iv; v.ir = ir; v.e_we = ew; v.e_rd = er; v.e_wd = ed;
      v.e_busy = eb; v.e_ready = ey;
      return v;
   endfunction

   initial begin
      //                av ar  ad            mv mr  md            iv ir   we rd  wd            busy        rdy
      vecs[0]  = mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0,  1, 5, 32'hDEADBEEF, 32'h0,      1);
      vecs[1]  = mk(1, 0, 32'h11111111, 0, 0, 0,            0, 0,  0, 5, 32'hDEADBEEF, 32'h0,      1);
      vecs[2]  = mk(0, 0, 0,            0, 0, 0,            1, 7,  0, 5, 32'hDEADBEEF, 32'h80,     1);
      vecs[3]  = mk(0, 0, 0,            1, 7, 32'h12345678, 0, 0,  0, 5, 32'hDEADBEEF, 32'h80,     1);
      vecs[4]  = mk(0, 0, 0,            0, 0, 0,            0, 0,  1, 7, 32'h12345678, 32'h0,      1);
      vecs[5]  = mk(0, 0, 0,            0, 0, 0,            0, 0,  0, 7, 32'h12345678, 32'h0,      1);
      vecs[6]  = mk(1, 3, 32'hA0,       1, 1, 32'h100,      1, 1,  1, 3, 32'hA0,       32'h2,      1);
      vecs[7]  = mk(1, 3, 32'hA1,       1, 2, 32'h200,      1, 2,  1, 3, 32'hA1,       32'h6,      0);
      vecs[8]  = mk(1, 3, 32'hA2,       1, 4, 32'h400,      0, 0,  1, 3, 32'hA2,       32'h6,      0);
      vecs[9]  = mk(0, 0, 0,            0, 0, 0,            0, 0,  1, 1, 32'h100,      32'h4,      1);
      vecs[10] = mk(0, 0, 0,            0, 0, 0,            0, 0,  1, 2, 32'h200,      32'h0,      1);
      vecs[11] = mk(0, 0, 0,            0, 0, 0,            0, 0,  0, 2, 32'h200,      32'h0,      1);
      vecs[12] = mk(0, 0, 0,            0, 0, 0,            1, 9,  0, 2, 32'h200,      32'h200,    1);
      vecs[13] = mk(0, 0, 0,            1, 9, 32'h900,      0, 0,  0, 2, 32'h200,      32'h200,    1);
      vecs[14] = mk(0, 0, 0,            0, 0, 0,            1, 9,  1, 9, 32'h900,      32'h200,    1);
      vecs[15] = mk(0, 0, 0,            0, 0, 0,            0, 0,  0, 9, 32'h900,      32'h200,    1);
      vecs[16] = mk(0, 0, 0,            1, 0, 32'hAAA,      0, 0,  0, 9, 32'h900,      32'h200,    1);
      vecs[17] = mk(0, 0, 0,            0, 0, 0,            0, 0,  0, 0, 32'hAAA,      32'h200,    1);
      vecs[18] = mk(0, 0, 0,            1, 10, 32'hA0A,     0, 0,  0, 0, 32'hAAA,      32'h200,    1);
      vecs[19] = mk(0, 0, 0,            1, 11, 32'hB0B,     0, 0,  1, 10, 32'hA0A,     32'h200,    1);
      vecs[20] = mk(0, 0, 0,            0, 0, 0,            0, 0,  1, 11, 32'hB0B,     32'h200,    1);
      vecs[21] = mk(0, 0, 0,            0, 0, 0,            0, 0,  0, 11, 32'hB0B,     32'h200,    1);
   end

   // ---------------- test sequence ----------------
   initial begin
      rst_n = 1'b0;
      idle();
      model_reset();
      #1;
      chk("reset_rf_we", {31'd0, rf_we}, 32'd0);
      chk("reset_busy", busy, 32'd0);
      chk("reset_ready", {31'd0, mem_ready}, 32'd1);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      // Directed table
      for (int i = 0; i < 22; i++) begin
         drive(vecs[i].av, vecs[i].ar, vecs[i].ad, vecs[i].mv, vecs[i].mr,
               vecs[i].md, vecs[i].iv, vecs[i].ir);
         cycle();
         chk($sformatf("vec%0d_we", i), {31'd0, rf_we}, {31'd0, vecs[i].e_we});
         chk($sformatf("vec%0d_rd", i), {27'd0, rf_rd}, {27'd0, vecs[i].e_rd});
         chk($sformatf("vec%0d_wd", i), rf_wd, vecs[i].e_wd);
         chk($sformatf("vec%0d_busy", i), busy, vecs[i].e_busy);
         chk($sformatf("vec%0d_ready", i), {31'd0, mem_ready}, {31'd0, vecs[i].e_ready});
      end

      // Async reset mid-traffic with two loads queued while ALU holds the port
      drive(1, 3, 32'hC0, 1, 12, 32'hC12, 1, 12); cycle();
      drive(1, 3, 32'hC1, 1, 13, 32'hC13, 1, 13); cycle();
      chk("pre_reset_full", {31'd0, mem_ready}, 32'd0);
      chk("pre_reset_we", {31'd0, rf_we}, 32'd1);
      idle();
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_we", {31'd0, rf_we}, 32'd0);
      chk("async_rst_busy", busy, 32'd0);
      chk("async_rst_ready", {31'd0, mem_ready}, 32'd1);
      model_reset();
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("post_reset_we%0d", i), {31'd0, rf_we}, 32'd0);
      end

      // Randomized traffic against the reference model
      for (int i = 0; i < 600; i++) begin
         drive(($urandom_range(0, 99) < 45),
               (($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31))),
               $urandom(),
               ($urandom_range(0, 99) < 55),
               (($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31))),
               $urandom(),
               ($urandom_range(0, 99) < 30),
               5'($urandom_range(0, 31)));
         cycle();
         chk("rnd_we", {31'd0, rf_we}, {31'd0, m_we});
         chk("rnd_rd", {27'd0, rf_rd}, {27'd0, m_rd});
         chk("rnd_wd", rf_wd, m_wd);
         chk("rnd_busy", busy, m_busy);
         chk("rnd_ready", {31'd0, mem_ready}, {31'd0, (m_q.size() < DEPTH)});
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back arbiter and load scoreboard that drives the register file's single write port (we/rd/wd). It merges single-cycle ALU results with multi-cycle load results: ALU results have priority, load results are queued in a small FIFO, and a per-register busy vector tells decode which destinations still await a load. It sits between the execute/memory stages and the register file write port.

## Interface
- DEPTH, 2, load-result FIFO entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- mem_valid  in  1  load result offered
- mem_ready  out  1  FIFO can accept a load result
- mem_rd  in  5  load destination register
- mem_data  in  32  load data
- issue_valid  in  1  a load is being issued this cycle
- issue_rd  in  5  destination of the issued load
- rf_we  out  1  register-file write enable (registered)
- rf_rd  out  5  register-file write address (registered)
- rf_wd  out  32  register-file write data (registered)
- busy  out  32  busy[r]=1: load to xr outstanding

## Operation
- Reset values: rf_we=0, rf_rd=0, rf_wd=0, busy=0, FIFO empty (count=0), mem_ready=1.
- mem_ready = (count < DEPTH), from registered count only; push when mem_valid & mem_ready.
- Port arbitration each cycle:
  - alu_valid & alu_rd≠0 → ALU owns the port: rf_we←1, rf_rd←alu_rd, rf_wd←alu_data. No FIFO pop.
  - Otherwise, FIFO non-empty → pop head: rf_we←(head_rd≠0), rf_rd←head_rd, rf_wd←head_data.
  - Otherwise rf_we←0; rf_rd/rf_wd hold their previous values.
- alu_valid with alu_rd=0 is discarded and does not take the port.
- A load to x0 is still pushed and popped in order but produces no write.
- No same-cycle bypass: a pushed entry is poppable from the next cycle. Simultaneous push and pop are legal; count is unchanged.
- FIFO order is strictly preserved; pointers wrap modulo DEPTH.
- Scoreboard:
  - busy[r] is set at the edge where issue_valid & issue_rd=r, for r≠0.
  - busy[r] is cleared at the edge where a FIFO pop with head_rd=r is registered.
  - Set and clear of the same r on the same edge → set wins.
  - busy[0] is always 0.
  - An ALU write to a busy register is performed and leaves busy unchanged. Decode is responsible for stalling.
- ALU results can starve the FIFO indefinitely; backpressure reaches the load unit through mem_ready.

## Timing
- ALU: alu_valid sampled at edge E → rf_we=1 during cycle E..E+1. Latency 1.
- Load, empty FIFO, no ALU traffic: accepted at edge E → popped at edge E+1 → rf_we=1 after E+1. Latency 2.
- Each stalled ALU cycle adds 1 cycle of load latency.
- busy changes are visible one cycle after the triggering edge (registered).
- rst_n low at any time: all state and outputs return to reset values immediately. Queued loads are dropped and busy is cleared.
- Throughput: one register-file write per cycle maximum.

## Test plan
- Reset: assert rst_n=0 mid-traffic with 2 entries queued → rf_we=0, busy=0, mem_ready=1 without waiting for a clock edge; no writes appear after release.
- ALU path: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF at edge E → after E, rf_we=1, rf_rd=5, rf_wd=0xDEADBEEF; alu_rd=0 → rf_we=0.
- Load path plus scoreboard:
  - issue_valid, issue_rd=7 → busy[7]=1.
  - Then mem_valid, mem_rd=7, mem_data=0x12345678 accepted at E → write appears after E+1 and busy[7]=0 after E+1.
- Priority and backpressure:
  - Hold alu_valid=1 (rd=3) while pushing 3 loads with DEPTH=2 → mem_ready=0 after 2 accepted; no load writes occur.
  - Drop alu_valid → loads are written in order in 2 consecutive cycles; mem_ready returns to 1.
- Corner cases:
  - Re-issue to x9 on the same edge that pops the old x9 load → busy[9] stays 1.
  - Load to x0 → popped with rf_we=0, busy unchanged.
  - Simultaneous push and pop at count=1 → count remains 1.
